// File: rtl/wb_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_2m
// Purpose  : Two-master Wishbone arbiter with round-robin grant and bus lock.
// Options  : define WB_ARB_TIMEOUT_EN to abort unanswered strobes with ERR.
// Revision : 1.0  initial release
// ============================================================================
module wb_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        p_clk,
    input  logic        p_resetn,

    input  logic        p_m0_wb_CYC_I,
    input  logic        p_m0_wb_STB_I,
    input  logic        p_m0_wb_WE_I,
    input  logic        p_m0_wb_LOCK_I,
    input  logic [31:0] p_m0_wb_ADR_I,
    input  logic [31:0] p_m0_wb_DAT_I,
    input  logic [3:0]  p_m0_wb_SEL_I,
    output logic [31:0] p_m0_wb_DAT_O,
    output logic        p_m0_wb_ACK_O,
    output logic        p_m0_wb_ERR_O,
    output logic        p_m0_wb_RTY_O,

    input  logic        p_m1_wb_CYC_I,
    input  logic        p_m1_wb_STB_I,
    input  logic        p_m1_wb_WE_I,
    input  logic        p_m1_wb_LOCK_I,
    input  logic [31:0] p_m1_wb_ADR_I,
    input  logic [31:0] p_m1_wb_DAT_I,
    input  logic [3:0]  p_m1_wb_SEL_I,
    output logic [31:0] p_m1_wb_DAT_O,
    output logic        p_m1_wb_ACK_O,
    output logic        p_m1_wb_ERR_O,
    output logic        p_m1_wb_RTY_O,

    output logic        p_s_wb_CYC_O,
    output logic        p_s_wb_STB_O,
    output logic        p_s_wb_WE_O,
    output logic        p_s_wb_LOCK_O,
    output logic [31:0] p_s_wb_ADR_O,
    output logic [31:0] p_s_wb_DAT_O,
    output logic [3:0]  p_s_wb_SEL_O,
    input  logic [31:0] p_s_wb_DAT_I,
    input  logic        p_s_wb_ACK_I,
    input  logic        p_s_wb_ERR_I,
    input  logic        p_s_wb_RTY_I,

    output logic [1:0]  p_grant
);

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_bad
            $error("wb_arbiter_2m: TIMEOUT_CYCLES must be within 2..255");
        end
    endgenerate

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   last_gnt_q, last_gnt_d;

    logic   w_gnt_stb;
    logic   w_s_resp;
    logic   w_to_hit;

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (p_m0_wb_CYC_I && p_m1_wb_CYC_I) begin
                    state_d = last_gnt_q ? GNT0 : GNT1;
                end else if (p_m0_wb_CYC_I) begin
                    state_d = GNT0;
                end else if (p_m1_wb_CYC_I) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!(p_m0_wb_CYC_I || p_m0_wb_LOCK_I)) begin
                    state_d = p_m1_wb_CYC_I ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!(p_m1_wb_CYC_I || p_m1_wb_LOCK_I)) begin
                    state_d = p_m0_wb_CYC_I ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == GNT0 && state_q != GNT0) begin
            last_gnt_d = 1'b0;
        end else if (state_d == GNT1 && state_q != GNT1) begin
            last_gnt_d = 1'b1;
        end
    end

    assign p_grant  = state_q;
    assign w_s_resp = p_s_wb_ACK_I | p_s_wb_ERR_I | p_s_wb_RTY_I;

    always_comb begin
        w_gnt_stb = 1'b0;
        case (state_q)
            GNT0:    w_gnt_stb = p_m0_wb_STB_I;
            GNT1:    w_gnt_stb = p_m1_wb_STB_I;
            default: w_gnt_stb = 1'b0;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] to_cnt_q, to_cnt_d;

    assign w_to_hit = (state_q != IDLE) && w_gnt_stb && (to_cnt_q == C_TO_LAST);

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (w_to_hit || w_s_resp || (state_d != state_q)) begin
            to_cnt_d = '0;
        end else if (w_gnt_stb) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    // Slave request path follows the current grant; idle drives all zeros.
    always_comb begin
        p_s_wb_CYC_O  = 1'b0;
        p_s_wb_STB_O  = 1'b0;
        p_s_wb_WE_O   = 1'b0;
        p_s_wb_LOCK_O = 1'b0;
        p_s_wb_ADR_O  = '0;
        p_s_wb_DAT_O  = '0;
        p_s_wb_SEL_O  = '0;
        case (state_q)
            GNT0: begin
                p_s_wb_CYC_O  = p_m0_wb_CYC_I;
                p_s_wb_STB_O  = p_m0_wb_STB_I & ~w_to_hit;
                p_s_wb_WE_O   = p_m0_wb_WE_I;
                p_s_wb_LOCK_O = p_m0_wb_LOCK_I;
                p_s_wb_ADR_O  = p_m0_wb_ADR_I;
                p_s_wb_DAT_O  = p_m0_wb_DAT_I;
                p_s_wb_SEL_O  = p_m0_wb_SEL_I;
            end
            GNT1: begin
                p_s_wb_CYC_O  = p_m1_wb_CYC_I;
                p_s_wb_STB_O  = p_m1_wb_STB_I & ~w_to_hit;
                p_s_wb_WE_O   = p_m1_wb_WE_I;
                p_s_wb_LOCK_O = p_m1_wb_LOCK_I;
                p_s_wb_ADR_O  = p_m1_wb_ADR_I;
                p_s_wb_DAT_O  = p_m1_wb_DAT_I;
                p_s_wb_SEL_O  = p_m1_wb_SEL_I;
            end
            default: ;
        endcase
    end

    // Responses reach only the granted master; a timeout replaces them with ERR.
    always_comb begin
        p_m0_wb_DAT_O = '0;
        p_m0_wb_ACK_O = 1'b0;
        p_m0_wb_ERR_O = 1'b0;
        p_m0_wb_RTY_O = 1'b0;
        p_m1_wb_DAT_O = '0;
        p_m1_wb_ACK_O = 1'b0;
        p_m1_wb_ERR_O = 1'b0;
        p_m1_wb_RTY_O = 1'b0;
        case (state_q)
            GNT0: begin
                p_m0_wb_DAT_O = p_s_wb_DAT_I;
                p_m0_wb_ACK_O = p_s_wb_ACK_I & ~w_to_hit;
                p_m0_wb_ERR_O = p_s_wb_ERR_I | w_to_hit;
                p_m0_wb_RTY_O = p_s_wb_RTY_I & ~w_to_hit;
            end
            GNT1: begin
                p_m1_wb_DAT_O = p_s_wb_DAT_I;
                p_m1_wb_ACK_O = p_s_wb_ACK_I & ~w_to_hit;
                p_m1_wb_ERR_O = p_s_wb_ERR_I | w_to_hit;
                p_m1_wb_RTY_O = p_s_wb_RTY_I & ~w_to_hit;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter_2m
// Purpose  : Directed self-checking bench for wb_arbiter_2m.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_arbiter_2m;

    logic        p_clk;
    logic        p_resetn;
    logic        p_m0_wb_CYC_I, p_m0_wb_STB_I, p_m0_wb_WE_I, p_m0_wb_LOCK_I;
    logic [31:0] p_m0_wb_ADR_I, p_m0_wb_DAT_I;
    logic [3:0]  p_m0_wb_SEL_I;
    logic [31:0] p_m0_wb_DAT_O;
    logic        p_m0_wb_ACK_O, p_m0_wb_ERR_O, p_m0_wb_RTY_O;
    logic        p_m1_wb_CYC_I, p_m1_wb_STB_I, p_m1_wb_WE_I, p_m1_wb_LOCK_I;
    logic [31:0] p_m1_wb_ADR_I, p_m1_wb_DAT_I;
    logic [3:0]  p_m1_wb_SEL_I;
    logic [31:0] p_m1_wb_DAT_O;
    logic        p_m1_wb_ACK_O, p_m1_wb_ERR_O, p_m1_wb_RTY_O;
    logic        p_s_wb_CYC_O, p_s_wb_STB_O, p_s_wb_WE_O, p_s_wb_LOCK_O;
    logic [31:0] p_s_wb_ADR_O, p_s_wb_DAT_O;
    logic [3:0]  p_s_wb_SEL_O;
    logic [31:0] p_s_wb_DAT_I;
    logic        p_s_wb_ACK_I, p_s_wb_ERR_I, p_s_wb_RTY_I;
    logic [1:0]  p_grant;

    logic [7:0]  s_ctl;
    logic [2:0]  m0_rsp, m1_rsp;
    int          vectors;
    int          miscompares;
    int          n_gnt0, n_gnt1;

    assign s_ctl  = {p_s_wb_CYC_O, p_s_wb_STB_O, p_s_wb_WE_O, p_s_wb_LOCK_O, p_s_wb_SEL_O};
    assign m0_rsp = {p_m0_wb_ACK_O, p_m0_wb_ERR_O, p_m0_wb_RTY_O};
    assign m1_rsp = {p_m1_wb_ACK_O, p_m1_wb_ERR_O, p_m1_wb_RTY_O};

    wb_arbiter_2m #(.TIMEOUT_CYCLES(16)) dut (
        .p_clk(p_clk), .p_resetn(p_resetn),
        .p_m0_wb_CYC_I(p_m0_wb_CYC_I), .p_m0_wb_STB_I(p_m0_wb_STB_I),
        .p_m0_wb_WE_I(p_m0_wb_WE_I), .p_m0_wb_LOCK_I(p_m0_wb_LOCK_I),
        .p_m0_wb_ADR_I(p_m0_wb_ADR_I), .p_m0_wb_DAT_I(p_m0_wb_DAT_I),
        .p_m0_wb_SEL_I(p_m0_wb_SEL_I), .p_m0_wb_DAT_O(p_m0_wb_DAT_O),
        .p_m0_wb_ACK_O(p_m0_wb_ACK_O), .p_m0_wb_ERR_O(p_m0_wb_ERR_O),
        .p_m0_wb_RTY_O(p_m0_wb_RTY_O),
        .p_m1_wb_CYC_I(p_m1_wb_CYC_I), .p_m1_wb_STB_I(p_m1_wb_STB_I),
        .p_m1_wb_WE_I(p_m1_wb_WE_I), .p_m1_wb_LOCK_I(p_m1_wb_LOCK_I),
        .p_m1_wb_ADR_I(p_m1_wb_ADR_I), .p_m1_wb_DAT_I(p_m1_wb_DAT_I),
        .p_m1_wb_SEL_I(p_m1_wb_SEL_I), .p_m1_wb_DAT_O(p_m1_wb_DAT_O),
        .p_m1_wb_ACK_O(p_m1_wb_ACK_O), .p_m1_wb_ERR_O(p_m1_wb_ERR_O),
        .p_m1_wb_RTY_O(p_m1_wb_RTY_O),
        .p_s_wb_CYC_O(p_s_wb_CYC_O), .p_s_wb_STB_O(p_s_wb_STB_O),
        .p_s_wb_WE_O(p_s_wb_WE_O), .p_s_wb_LOCK_O(p_s_wb_LOCK_O),
        .p_s_wb_ADR_O(p_s_wb_ADR_O), .p_s_wb_DAT_O(p_s_wb_DAT_O),
        .p_s_wb_SEL_O(p_s_wb_SEL_O), .p_s_wb_DAT_I(p_s_wb_DAT_I),
        .p_s_wb_ACK_I(p_s_wb_ACK_I), .p_s_wb_ERR_I(p_s_wb_ERR_I),
        .p_s_wb_RTY_I(p_s_wb_RTY_I),
        .p_grant(p_grant)
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge p_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; n_gnt0 = 0; n_gnt1 = 0;
        p_resetn = 1'b0;
        p_m0_wb_CYC_I = 1'b1; p_m0_wb_STB_I = 1'b1; p_m0_wb_WE_I = 1'b1; p_m0_wb_LOCK_I = 1'b0;
        p_m0_wb_ADR_I = 32'hDEAD_0000; p_m0_wb_DAT_I = 32'h5555_5555; p_m0_wb_SEL_I = 4'hF;
        p_m1_wb_CYC_I = 1'b0; p_m1_wb_STB_I = 1'b0; p_m1_wb_WE_I = 1'b0; p_m1_wb_LOCK_I = 1'b0;
        p_m1_wb_ADR_I = 32'h0; p_m1_wb_DAT_I = 32'h0; p_m1_wb_SEL_I = 4'h0;
        p_s_wb_DAT_I = 32'hFFFF_FFFF; p_s_wb_ACK_I = 1'b1; p_s_wb_ERR_I = 1'b1; p_s_wb_RTY_I = 1'b1;

        // Reset state, with a master requesting and the slave responding.
        tick();
        chk("rst_grant",  32'(p_grant), 32'h0);
        chk("rst_s_ctl",  32'(s_ctl), 32'h0);
        chk("rst_s_adr",  p_s_wb_ADR_O, 32'h0);
        chk("rst_s_dat",  p_s_wb_DAT_O, 32'h0);
        chk("rst_m0_dat", p_m0_wb_DAT_O, 32'h0);
        chk("rst_m0_rsp", 32'(m0_rsp), 32'h0);
        chk("rst_m1_rsp", 32'(m1_rsp), 32'h0);
        p_m0_wb_CYC_I = 1'b0; p_m0_wb_STB_I = 1'b0;
        p_s_wb_ACK_I = 1'b0; p_s_wb_ERR_I = 1'b0; p_s_wb_RTY_I = 1'b0;
        p_s_wb_DAT_I = 32'h0;
        tick();
        p_resetn = 1'b1;

        // Simultaneous first request: m0 wins, then hand-over without idle.
        p_m0_wb_CYC_I = 1'b1; p_m0_wb_STB_I = 1'b1; p_m0_wb_ADR_I = 32'h10; p_m0_wb_DAT_I = 32'h11;
        p_m1_wb_CYC_I = 1'b1; p_m1_wb_STB_I = 1'b1; p_m1_wb_WE_I = 1'b1;
        p_m1_wb_ADR_I = 32'h20; p_m1_wb_DAT_I = 32'h22;
        p_s_wb_ACK_I = 1'b1;
        tick();
        chk("tie_grant0",  32'(p_grant), 32'h1);
        chk("tie_s_adr0",  p_s_wb_ADR_O, 32'h10);
        chk("tie_m0_ack",  32'(p_m0_wb_ACK_O), 32'h1);
        chk("tie_m1_ack",  32'(p_m1_wb_ACK_O), 32'h0);
        p_m0_wb_CYC_I = 1'b0; p_m0_wb_STB_I = 1'b0;
        #1;
        chk("rel_m0_ack",  32'(p_m0_wb_ACK_O), 32'h1);
        tick();
        chk("tie_grant1",  32'(p_grant), 32'h2);
        chk("tie_s_adr1",  p_s_wb_ADR_O, 32'h20);
        chk("tie_s_dat1",  p_s_wb_DAT_O, 32'h22);
        chk("tie_m1_ack1", 32'(p_m1_wb_ACK_O), 32'h1);
        chk("tie_m0_ack1", 32'(p_m0_wb_ACK_O), 32'h0);
        p_m1_wb_CYC_I = 1'b0; p_m1_wb_STB_I = 1'b0;
        tick();
        chk("tie_idle",    32'(p_grant), 32'h0);
        chk("tie_idle_s",  32'(s_ctl), 32'h0);

        // Fairness: both masters keep re-requesting single writes.
        p_m0_wb_CYC_I = 1'b1; p_m0_wb_STB_I = 1'b1;
        p_m1_wb_CYC_I = 1'b1; p_m1_wb_STB_I = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("fair_grant", 32'(p_grant), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (p_grant == 2'b01) n_gnt0++;
            if (p_grant == 2'b10) n_gnt1++;
            if (k % 2 == 0) begin
                p_m0_wb_CYC_I = 1'b0; p_m0_wb_STB_I = 1'b0;
                tick();
                p_m0_wb_CYC_I = 1'b1; p_m0_wb_STB_I = 1'b1;
            end else begin
                p_m1_wb_CYC_I = 1'b0; p_m1_wb_STB_I = 1'b0;
                tick();
                p_m1_wb_CYC_I = 1'b1; p_m1_wb_STB_I = 1'b1;
            end
        end
        chk("fair_n_m0", 32'(n_gnt0), 32'd4);
        chk("fair_n_m1", 32'(n_gnt1), 32'd4);
        p_m0_wb_CYC_I = 1'b0; p_m0_wb_STB_I = 1'b0;
        p_m1_wb_CYC_I = 1'b0; p_m1_wb_STB_I = 1'b0;
        tick();
        chk("fair_idle", 32'(p_grant), 32'h0);

        // Master 0 alone writes 0x2A to 0xb0000004.
        p_m0_wb_CYC_I = 1'b1; p_m0_wb_STB_I = 1'b1; p_m0_wb_WE_I = 1'b1; p_m0_wb_SEL_I = 4'hF;
        p_m0_wb_ADR_I = 32'hb000_0004; p_m0_wb_DAT_I = 32'h0000_002A;
        p_s_wb_DAT_I = 32'h1234_5678; p_s_wb_ACK_I = 1'b1;
        #1;
        chk("m0_lat_grant", 32'(p_grant), 32'h0);
        chk("m0_lat_s_ctl", 32'(s_ctl), 32'h0);
        tick();
        chk("m0_grant",  32'(p_grant), 32'h1);
        chk("m0_s_adr",  p_s_wb_ADR_O, 32'hb000_0004);
        chk("m0_s_dat",  p_s_wb_DAT_O, 32'h0000_002A);
        chk("m0_s_ctl",  32'(s_ctl), 32'hEF);
        chk("m0_ack",    32'(p_m0_wb_ACK_O), 32'h1);
        chk("m0_rdat",   p_m0_wb_DAT_O, 32'h1234_5678);
        chk("m0_m1_dat", p_m1_wb_DAT_O, 32'h0);
        chk("m0_m1_rsp", 32'(m1_rsp), 32'h0);
        p_m0_wb_CYC_I = 1'b0; p_m0_wb_STB_I = 1'b0;
        tick();
        chk("m0_idle", 32'(p_grant), 32'h0);
        chk("m0_idle_rsp", 32'(m0_rsp), 32'h0);

        // Lock held across two m0 bursts while m1 waits.
        p_m0_wb_CYC_I = 1'b1; p_m0_wb_STB_I = 1'b1; p_m0_wb_LOCK_I = 1'b1;
        tick();
        chk("lk_grant_a", 32'(p_grant), 32'h1);
        chk("lk_s_lock",  32'(p_s_wb_LOCK_O), 32'h1);
        p_m1_wb_CYC_I = 1'b1; p_m1_wb_STB_I = 1'b1;
        p_m0_wb_CYC_I = 1'b0; p_m0_wb_STB_I = 1'b0;
        tick();
        chk("lk_grant_gap", 32'(p_grant), 32'h1);
        chk("lk_m1_ack",    32'(p_m1_wb_ACK_O), 32'h0);
        p_m0_wb_CYC_I = 1'b1; p_m0_wb_STB_I = 1'b1;
        tick();
        chk("lk_grant_b", 32'(p_grant), 32'h1);
        p_m0_wb_CYC_I = 1'b0; p_m0_wb_STB_I = 1'b0; p_m0_wb_LOCK_I = 1'b0;
        tick();
        chk("lk_grant_m1", 32'(p_grant), 32'h2);
        p_m1_wb_CYC_I = 1'b0; p_m1_wb_STB_I = 1'b0;
        tick();
        chk("lk_idle", 32'(p_grant), 32'h0);

        // Slave never answers a strobe from m0.
        p_s_wb_ACK_I = 1'b0;
        p_m0_wb_CYC_I = 1'b1; p_m0_wb_STB_I = 1'b1; p_m0_wb_WE_I = 1'b0;
        tick();
        for (int n = 1; n <= 16; n++) begin
            if (n == 15) begin
                chk("to_n15_err", 32'(p_m0_wb_ERR_O), 32'h0);
                chk("to_n15_stb", 32'(p_s_wb_STB_O), 32'h1);
            end
            if (n == 16) begin
`ifdef WB_ARB_TIMEOUT_EN
                chk("to_n16_err", 32'(p_m0_wb_ERR_O), 32'h1);
                chk("to_n16_stb", 32'(p_s_wb_STB_O), 32'h0);
`else
                chk("to_n16_err", 32'(p_m0_wb_ERR_O), 32'h0);
                chk("to_n16_stb", 32'(p_s_wb_STB_O), 32'h1);
`endif
            end
            if (n < 16) tick();
        end
        p_m0_wb_CYC_I = 1'b0; p_m0_wb_STB_I = 1'b0;
        tick();
        chk("to_idle", 32'(p_grant), 32'h0);

        // Reset pulled low during an m1 tenure.
        p_m1_wb_CYC_I = 1'b1; p_m1_wb_STB_I = 1'b1; p_s_wb_ACK_I = 1'b1;
        tick();
        chk("mr_grant1", 32'(p_grant), 32'h2);
        chk("mr_m1_ack", 32'(p_m1_wb_ACK_O), 32'h1);
        #2;
        p_resetn = 1'b0;
        #1;
        chk("mr_grant",  32'(p_grant), 32'h0);
        chk("mr_s_ctl",  32'(s_ctl), 32'h0);
        chk("mr_s_adr",  p_s_wb_ADR_O, 32'h0);
        chk("mr_m1_rsp", 32'(m1_rsp), 32'h0);
        p_m0_wb_CYC_I = 1'b1; p_m0_wb_STB_I = 1'b1;
        tick();
        p_resetn = 1'b1;
        tick();
        chk("mr_tie_m0", 32'(p_grant), 32'h1);
        p_m0_wb_CYC_I = 1'b0; p_m0_wb_STB_I = 1'b0;
        p_m1_wb_CYC_I = 1'b0; p_m1_wb_STB_I = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: number of STB-high cycles without a slave response before the arbiter aborts the access (range 2..255).
REQ-002 Port p_clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port p_resetn, input, 1: reset, asynchronous and active-low.
REQ-004 Ports p_m0_wb_CYC_I, STB_I, WE_I, LOCK_I, input, 1 each: master 0 cycle, strobe, write-enable and lock.
REQ-005 Ports p_m0_wb_ADR_I and p_m0_wb_DAT_I, input, 32 each; p_m0_wb_SEL_I, input, 4: master 0 address, write data and byte selects.
REQ-006 Ports p_m0_wb_DAT_O, output, 32; p_m0_wb_ACK_O, ERR_O, RTY_O, output, 1 each: master 0 read data and responses.
REQ-007 Ports p_m1_wb_* SHALL be identical to REQ-004..REQ-006 and carry master 1.
REQ-008 Ports p_s_wb_CYC_O, STB_O, WE_O, LOCK_O, output, 1 each; ADR_O and DAT_O, output, 32; SEL_O, output, 4: slave-side request.
REQ-009 Ports p_s_wb_DAT_I, input, 32; p_s_wb_ACK_I, ERR_I, RTY_I, input, 1 each: slave-side responses.
REQ-010 Port p_grant, output, 2: one-hot registered grant; bit0 = master 0, bit1 = master 1, 00 = idle.

Function
REQ-011 The FSM SHALL have three states: IDLE, GNT0, GNT1; p_grant SHALL equal 00, 01 and 10 respectively.
REQ-012 A master requests when its CYC_I is high.
REQ-013 IDLE with exactly one requester: the next state SHALL be that master's GNT state.
REQ-014 IDLE with both requesting: grant SHALL go to the master not granted last (round-robin on register last_gnt).
REQ-015 Arbitration latency: a request seen in IDLE SHALL be granted on the next rising edge, and the slave sees the master's signals from that cycle.
REQ-016 GNTx SHALL be held while master x CYC_I or LOCK_I is high.
REQ-017 When GNTx releases and the other master is requesting, the FSM SHALL move directly to the other GNT state with no idle cycle.
REQ-018 When GNTx releases and the other master is not requesting, the FSM SHALL move to IDLE.
REQ-019 On every transition into GNTx, last_gnt SHALL be updated to x.
REQ-020 In GNTx, all slave request outputs SHALL be combinationally driven from master x.
REQ-021 In GNTx, slave DAT_I/ACK/ERR/RTY SHALL be routed to master x only.
REQ-022 A non-granted master SHALL see DAT_O = 0 and ACK/ERR/RTY = 0.
REQ-023 In IDLE, all p_s_wb_* outputs SHALL be 0.
REQ-024 A master deasserting CYC_I mid-transfer ends its tenure; a slave ACK arriving in the release cycle SHALL still be forwarded to that master.
REQ-025 LOCK_I high with CYC_I low SHALL keep the grant, so a locked read-modify-write pair cannot be interleaved.

Reset
REQ-026 While p_resetn = 0: FSM = IDLE, p_grant = 00, last_gnt = 1 (master 0 wins the first tie), timeout counter = 0.
REQ-027 While p_resetn = 0: all p_s_wb_* outputs SHALL be 0, and all master DAT_O/ACK/ERR/RTY SHALL be 0.
REQ-028 Reset asserted mid-transfer SHALL abort it immediately, with no response delivered.

Configuration
REQ-029 Macro WB_ARB_TIMEOUT_EN: when defined, an 8-bit counter SHALL increment each cycle the granted master STB_O is high and the slave ACK/ERR/RTY are all low.
REQ-030 With WB_ARB_TIMEOUT_EN defined, the counter SHALL clear on any slave response or grant change.
REQ-031 With WB_ARB_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES-1 the arbiter SHALL for one cycle drive ERR_O = 1 to the granted master and force p_s_wb_STB_O = 0, then clear the counter.
REQ-032 With WB_ARB_TIMEOUT_EN undefined, no counter SHALL exist and ERR SHALL pass through from the slave unchanged.

Verification
REQ-033 Scenario (master 0 alone): m0 writes 0x0000002A to 0xb0000004 -> p_grant = 01 next cycle, slave sees ADR 0xb0000004 / DAT 0x0000002A, m0 ACK_O = 1, m1 outputs all 0.
REQ-034 Scenario (simultaneous first request): both masters raise CYC in the same cycle after reset -> GNT0 first; when m0 drops CYC, GNT1 on the next edge with no IDLE cycle.
REQ-035 Scenario (fairness): both masters issue back-to-back single writes for 8 tenures -> grants strictly alternate 01,10,01,... with 4 each.
REQ-036 Scenario (lock): m0 holds LOCK_I = 1 across two CYC bursts while m1 requests -> p_grant stays 01 until m0 LOCK_I = 0.
REQ-037 Scenario (timeout, WB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16, slave never acks) -> m0 ERR_O = 1 on the 16th STB cycle with p_s_wb_STB_O = 0 that cycle; undefined: no ERR.
REQ-038 Scenario (reset mid-transfer): p_resetn pulled low during GNT1 -> p_grant = 00 and all slave outputs 0 asynchronously; the first tie after release goes to m0.
